uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud.sv | 128 ++++++++++++
 tb/tb_uart_autobaud.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// UART baud-rate auto-calibration: times four bit-pairs of a 0x55 character
// and loads the measured cycles-per-bit into baud_edge.
module uart_autobaud #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int MIN_BDRT   = 9_600,
  parameter int BAUD_BITS  = $clog2((CLOCK_FREQ+(MIN_BDRT/2)-1)/(MIN_BDRT/2))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 calib_start,
  output logic [BAUD_BITS-1:0] baud_edge,
  output logic                 calib_busy,
  output logic                 locked,
  output logic                 calib_error
);

  localparam int                   CW       = BAUD_BITS + 3;
  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic [BAUD_BITS-1:0] BAUD_RST = BAUD_BITS'(CLOCK_FREQ / BAUD_RATE);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t         state, state_nx;
  logic [1:0]     sync_q;
  logic           line_prev, fall;
  logic [CW-1:0]  cnt, last_t, i0;
  logic [CW-1:0]  elapsed, interval, diff;
  logic [CW:0]    sum;
  logic [BAUD_BITS:0] result;
  logic [1:0]     edge_idx;
  logic           arm, start_meas, edge_rec, done_ok, done_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], serial_in};
      line_prev <= sync_q[1];
    end
  end

  assign fall = line_prev & ~sync_q[1];

  // elapsed is cycles since the start edge; timeout has priority so it never wraps
  assign elapsed  = cnt + CW'(1);
  assign interval = elapsed - last_t;
  assign diff     = (interval >= i0) ? (interval - i0) : (i0 - interval);
  assign sum      = {1'b0, elapsed} + (CW+1)'(4);
  assign result   = sum[CW:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    arm        = 1'b0;
    start_meas = 1'b0;
    edge_rec   = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: if (calib_start) begin
        arm      = 1'b1;
        state_nx = ARMED;
      end
      ARMED: if (fall) begin
        start_meas = 1'b1;
        state_nx   = MEASURE;
      end
      MEASURE: begin
        if (cnt == CNT_MAX) done_err = 1'b1;
        else if (fall) begin
          if (edge_idx != 2'd0 && diff > (i0 >> 2)) done_err = 1'b1;
          else if (edge_idx == 2'd3) begin
            if (result < (BAUD_BITS+1)'(16)) done_err = 1'b1;
            else                             done_ok  = 1'b1;
          end else edge_rec = 1'b1;
        end
        if (done_ok || done_err) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      last_t      <= '0;
      i0          <= '0;
      edge_idx    <= '0;
      baud_edge   <= BAUD_RST;
      calib_busy  <= 1'b0;
      locked      <= 1'b0;
      calib_error <= 1'b0;
    end else begin
      if (start_meas)           cnt <= '0;
      else if (state == MEASURE) cnt <= cnt + CW'(1);
      if (start_meas) begin
        last_t   <= '0;
        edge_idx <= '0;
      end else if (edge_rec) begin
        last_t   <= elapsed;
        edge_idx <= edge_idx + 2'd1;
        if (edge_idx == 2'd0) i0 <= interval;
      end
      if (arm) begin
        calib_busy  <= 1'b1;
        locked      <= 1'b0;
        calib_error <= 1'b0;
      end
      if (done_ok) begin
        calib_busy <= 1'b0;
        locked     <= 1'b1;
        baud_edge  <= result[BAUD_BITS-1:0];
      end
      if (done_err) begin
        calib_busy  <= 1'b0;
        calib_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: directed scenarios plus randomized frames checked
// against an edge-timestamp model of the calibration rules.
module tb_uart_autobaud;

  localparam int CF   = 4_000_000;
  localparam int BR   = 115_200;
  localparam int MB   = 9_600;
  localparam int BB   = $clog2((CF+(MB/2)-1)/(MB/2));
  localparam int TMO  = 2**(BB+3) - 1;
  localparam int RSTB = CF / BR;

  logic          clk, reset, serial_in, calib_start;
  logic [BB-1:0] baud_edge;
  logic          calib_busy, locked, calib_error;

  uart_autobaud #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .MIN_BDRT(MB)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .calib_start(calib_start),
    .baud_edge(baud_edge), .calib_busy(calib_busy), .locked(locked),
    .calib_error(calib_error)
  );

  always #5 clk = ~clk;

  int            n_chk, n_err;
  int            dur[10];
  logic [BB-1:0] exp_baud;
  logic          glitch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic void fill(input int p);
    for (int i = 0; i < 10; i++) dur[i] = p;
  endfunction

  // Reference: list the falling-edge times of the waveform, then apply the rules.
  function automatic void model(input logic [9:0] bits, output logic err, output int res);
    int   e[$];
    int   t = 0;
    logic prev = 1'b1;
    int   iref, ik, tt;
    err = 1'b0;
    res = 0;
    for (int i = 0; i < 10; i++) begin
      if (prev && !bits[i]) e.push_back(t);
      prev = bits[i];
      t += dur[i];
    end
    if (e.size() < 5) begin
      err = 1'b1;
      return;
    end
    iref = e[1] - e[0];
    for (int k = 2; k <= 4; k++) begin
      ik = e[k] - e[k-1];
      if (((ik > iref) ? ik - iref : iref - ik) > iref / 4) err = 1'b1;
    end
    tt = e[4] - e[0];
    if (tt > TMO) err = 1'b1;
    res = (tt + 4) / 8;
    if (res < 16) err = 1'b1;
  endfunction

  task automatic drive_bits(input logic [9:0] bits, input int lo, input int hi, input int pulse_at);
    for (int i = lo; i <= hi; i++) begin
      serial_in = bits[i];
      for (int c = 0; c < dur[i]; c++) begin
        if (i == pulse_at && c == 0) calib_start = 1'b1;
        @(negedge clk);
        calib_start = 1'b0;
        if (calib_busy && baud_edge !== exp_baud) glitch = 1'b1;
      end
    end
  endtask

  task automatic start_cal();
    @(negedge clk) calib_start = 1'b1;
    @(negedge clk) calib_start = 1'b0;
    @(negedge clk);
    chk("busy_armed", calib_busy, 1);
  endtask

  task automatic finish_and_check(input logic err, input int res);
    int n = 0;
    while (calib_busy && n < TMO + 200) begin
      @(negedge clk);
      n++;
      if (calib_busy && baud_edge !== exp_baud) glitch = 1'b1;
    end
    chk("done_in_time", calib_busy, 0);
    if (!err) exp_baud = res[BB-1:0];
    chk("locked", locked, !err);
    chk("calib_error", calib_error, err);
    chk("baud_edge", baud_edge, exp_baud);
    chk("no_glitch", glitch, 0);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_cal(input logic [9:0] bits, input int pulse_at);
    logic err;
    int   res;
    glitch = 1'b0;
    model(bits, err, res);
    start_cal();
    drive_bits(bits, 0, 9, pulse_at);
    finish_and_check(err, res);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", calib_busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_error", calib_error, 0);
    chk("rst_baud", baud_edge, RSTB);
  endtask

  initial begin
    int n, p, mode, nrand, j;
    logic [7:0] b;
    clk = 1'b0; reset = 1'b1; serial_in = 1'b1; calib_start = 1'b0;
    n_chk = 0; n_err = 0; nrand = 0; glitch = 1'b0;
    exp_baud = BB'(RSTB);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0x55 at the default rate, with lock latency from the 5th line edge
    fill(RSTB);
    start_cal();
    drive_bits(frame(8'h55), 0, 7, -1);
    serial_in = 1'b0;
    n = 0;
    while (!locked && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lock_latency_le3", (n <= 3), 1);
    chk("lock_busy", calib_busy, 0);
    chk("lock_baud", baud_edge, RSTB);
    repeat (RSTB) @(negedge clk);
    serial_in = 1'b1;
    repeat (RSTB + 5) @(negedge clk);

    // slowest supported rate, then a bad character
    fill(CF / MB);
    run_cal(frame(8'h55), -1);
    fill(RSTB);
    run_cal(frame(8'h0F), -1);

    // tolerance boundary: stretch one bit by exactly I0/4, then by one more
    fill(100); dur[3] = 150;
    run_cal(frame(8'h55), -1);
    fill(100); dur[3] = 151;
    run_cal(frame(8'h55), -1);

    // single edge then idle line: timeout
    fill(RSTB);
    glitch = 1'b0;
    start_cal();
    serial_in = 1'b0;
    n = 0;
    while (!calib_error && n < TMO + 50) begin
      @(negedge clk);
      n++;
      if (n == RSTB) serial_in = 1'b1;
    end
    chk("tmo_cycles", (n >= TMO && n <= TMO + 5), 1);
    chk("tmo_locked", locked, 0);
    chk("tmo_busy", calib_busy, 0);
    chk("tmo_baud", baud_edge, exp_baud);
    repeat (5) @(negedge clk);

    // calib_start in the same cycle the falling edge is detected
    serial_in = 1'b0;
    @(negedge clk);
    @(negedge clk) calib_start = 1'b1;
    @(negedge clk) calib_start = 1'b0;
    chk("coinc_busy", calib_busy, 1);
    repeat (10) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    begin
      logic err;
      int   res;
      fill(40);
      glitch = 1'b0;
      model(frame(8'h55), err, res);
      drive_bits(frame(8'h55), 0, 9, -1);
      finish_and_check(err, res);
    end

    // reset mid-measure, then a clean run with a start pulse while busy
    fill(RSTB);
    start_cal();
    drive_bits(frame(8'h55), 0, 4, -1);
    #3 reset = 1'b1;
    #1 chk_reset_vals();
    exp_baud = BB'(RSTB);
    @(negedge clk);
    reset = 1'b0;
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    fill(60);
    run_cal(frame(8'h55), 5);

    // randomized frames
    for (int t = 0; t < 14; t++) begin
      mode = $urandom_range(0, 9);
      p = $urandom_range(8, 500);
      fill(p);
      b = 8'h55;
      if (mode >= 5 && mode < 8) begin
        j = $urandom_range(1, 8);
        dur[j] = p + int'($urandom_range(0, p)) - p / 2;
      end else if (mode >= 8 && nrand < 2) begin
        nrand++;
        b = 8'($urandom_range(0, 255));
      end
      run_cal(frame(b), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
